// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared types and constants for the seven-segment display
//               driver: conversion FSM states, double-dabble iteration count
//               and active-low segment codes ({g,f,e,d,c,b,a}).
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

    // Binary-to-BCD conversion sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ssd_state_e;

    // One double-dabble step per input bit
    localparam int unsigned c_SHIFT_ITERS = 13;
    localparam logic [3:0]  c_SHIFT_LAST  = 4'(c_SHIFT_ITERS - 1);

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] c_SEG_0     = 7'b1000000;
    localparam logic [6:0] c_SEG_1     = 7'b1111001;
    localparam logic [6:0] c_SEG_2     = 7'b0100100;
    localparam logic [6:0] c_SEG_3     = 7'b0110000;
    localparam logic [6:0] c_SEG_4     = 7'b0011001;
    localparam logic [6:0] c_SEG_5     = 7'b0010010;
    localparam logic [6:0] c_SEG_6     = 7'b0000010;
    localparam logic [6:0] c_SEG_7     = 7'b1111000;
    localparam logic [6:0] c_SEG_8     = 7'b0000000;
    localparam logic [6:0] c_SEG_9     = 7'b0010000;
    localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

endpackage : ssd_pkg
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_decoder
// Description : Combinational BCD nibble to active-low seven-segment code.
//               Non-decimal nibbles (10..15) produce a blank digit.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decoder (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    import ssd_pkg::*;

    // Nibble to segment lookup; anything above 9 is blanked
    always_comb begin
        o_seg = c_SEG_BLANK;
        case (i_nibble)
            4'd0:    o_seg = c_SEG_0;
            4'd1:    o_seg = c_SEG_1;
            4'd2:    o_seg = c_SEG_2;
            4'd3:    o_seg = c_SEG_3;
            4'd4:    o_seg = c_SEG_4;
            4'd5:    o_seg = c_SEG_5;
            4'd6:    o_seg = c_SEG_6;
            4'd7:    o_seg = c_SEG_7;
            4'd8:    o_seg = c_SEG_8;
            4'd9:    o_seg = c_SEG_9;
            default: o_seg = c_SEG_BLANK;
        endcase
    end

endmodule : seven_seg_decoder
`default_nettype wire

// File: rtl/ssd_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : ssd_display_driver
// Description : Four-digit multiplexed seven-segment driver. A change on num
//               launches a 13-step double-dabble conversion; the resulting
//               BCD is scanned ones-to-thousands by a free-running refresh
//               counter with registered anode/segment outputs.
//               Optional macro SSD_LEADING_ZERO_BLANK_EN blanks leading
//               zero digits (the ones digit is always shown).
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_display_driver #(
    parameter int REFRESH_W = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] num,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        busy
);
    import ssd_pkg::*;

    ssd_state_e           r_state,    w_state_nxt;
    logic [12:0]          r_last_num, w_last_num_nxt;
    logic [12:0]          r_shift,    w_shift_nxt;
    logic [15:0]          r_scratch,  w_scratch_nxt;
    logic [3:0]           r_iter,     w_iter_nxt;
    logic [15:0]          r_bcd,      w_bcd_nxt;
    logic [REFRESH_W-1:0] r_refresh,  w_refresh_nxt;
    logic [3:0]           r_anode,    w_anode_nxt;
    logic [6:0]           r_seg,      w_seg_nxt;

    logic [15:0]          w_dabble;
    logic [1:0]           w_digit_idx;
    logic [3:0]           w_nibble;
    logic [6:0]           w_seg_dec;
    logic                 w_digit_blank;

    // Add-3 correction on every scratch nibble of 5 or more before the shift
    always_comb begin
        w_dabble = r_scratch;
        for (int i = 0; i < 4; i++) begin
            if (r_scratch[i*4 +: 4] >= 4'd5) begin
                w_dabble[i*4 +: 4] = r_scratch[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion sequencer: capture on change, 13 shift steps, publish result
    always_comb begin
        w_state_nxt    = r_state;
        w_last_num_nxt = r_last_num;
        w_shift_nxt    = r_shift;
        w_scratch_nxt  = r_scratch;
        w_iter_nxt     = r_iter;
        w_bcd_nxt      = r_bcd;
        case (r_state)
            IDLE: begin
                if (num != r_last_num) begin
                    w_last_num_nxt = num;
                    w_shift_nxt    = num;
                    w_scratch_nxt  = 16'd0;
                    w_iter_nxt     = 4'd0;
                    w_state_nxt    = SHIFT;
                end
            end
            SHIFT: begin
                {w_scratch_nxt, w_shift_nxt} = {w_dabble, r_shift} << 1;
                w_iter_nxt = r_iter + 4'd1;
                if (r_iter == c_SHIFT_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_bcd_nxt   = r_scratch;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Conversion state registers; reset discards any partial result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_last_num <= 13'd0;
            r_shift    <= 13'd0;
            r_scratch  <= 16'd0;
            r_iter     <= 4'd0;
            r_bcd      <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_last_num <= w_last_num_nxt;
            r_shift    <= w_shift_nxt;
            r_scratch  <= w_scratch_nxt;
            r_iter     <= w_iter_nxt;
            r_bcd      <= w_bcd_nxt;
        end
    end

    assign busy = (r_state != IDLE);

    // Scan position comes from the two MSBs of the free-running counter
    assign w_refresh_nxt = r_refresh + REFRESH_W'(1);
    assign w_digit_idx   = r_refresh[REFRESH_W-1 -: 2];
    assign w_nibble      = r_bcd[{w_digit_idx, 2'b00} +: 4];

    seven_seg_decoder u_seven_seg_decoder (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_dec)
    );

`ifdef SSD_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more significant digit are zero
    always_comb begin
        w_digit_blank = 1'b0;
        case (w_digit_idx)
            2'd3:    w_digit_blank = (r_bcd[15:12] == 4'd0);
            2'd2:    w_digit_blank = (r_bcd[15:8]  == 8'd0);
            2'd1:    w_digit_blank = (r_bcd[15:4]  == 12'd0);
            default: w_digit_blank = 1'b0;
        endcase
    end
`else
    assign w_digit_blank = 1'b0;
`endif

    // Next display drive: one active-low anode plus its decoded segments
    always_comb begin
        w_anode_nxt = ~(4'b0001 << w_digit_idx);
        w_seg_nxt   = w_seg_dec;
        if (w_digit_blank) begin
            w_anode_nxt = 4'b1111;
            w_seg_nxt   = c_SEG_BLANK;
        end
    end

    // Refresh counter and registered display outputs (glitch-free drive)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_anode   <= 4'b1111;
            r_seg     <= c_SEG_BLANK;
        end else begin
            r_refresh <= w_refresh_nxt;
            r_anode   <= w_anode_nxt;
            r_seg     <= w_seg_nxt;
        end
    end

    assign anode = r_anode;
    assign seg   = r_seg;

endmodule : ssd_display_driver
`default_nettype wire

// File: tb/tb_ssd_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_display_driver
// Description : Self-checking bench for ssd_display_driver (REFRESH_W=4).
//               Expected display contents are derived from decimal digit
//               arithmetic on the displayed value and a count of clock edges
//               since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_display_driver;

    localparam int REFRESH_W = 4;
    localparam int DIG_CYC   = 2 ** (REFRESH_W - 2);

    logic        clk;
    logic        rst;
    logic [12:0] num;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        busy;

    int n_cmp;
    int n_bad;
    int edges;

    logic [6:0] seg_tab [10];

    ssd_display_driver #(
        .REFRESH_W (REFRESH_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .num   (num),
        .anode (anode),
        .seg   (seg),
        .busy  (busy)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clock edges seen since reset was released
    always @(posedge clk or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    // Hard stop in case anything wedges
    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1);
    end

    function automatic int pow10(input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the current display drive against value v
    task automatic check_digit(input int v);
        int         idx;
        int         d;
        logic [3:0] ea;
        logic [6:0] es;
        if (edges == 0) begin
            ea = 4'b1111;
            es = 7'b1111111;
        end else begin
            idx = ((edges - 1) / DIG_CYC) % 4;
            d   = (v / pow10(idx)) % 10;
            ea  = ~(4'b0001 << idx);
            es  = seg_tab[d];
`ifdef SSD_LEADING_ZERO_BLANK_EN
            if (idx > 0 && v < pow10(idx)) begin
                ea = 4'b1111;
                es = 7'b1111111;
            end
`endif
        end
        chk("anode", {28'd0, anode}, {28'd0, ea});
        chk("seg", {25'd0, seg}, {25'd0, es});
    endtask

    task automatic check_scan(input int v, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check_digit(v);
            chk("busy_idle", {31'd0, busy}, 32'd0);
        end
    endtask

    // Drive a new value and measure the busy pulse
    task automatic convert(input int v);
        int guard;
        int len;
        @(negedge clk);
        num   = v[12:0];
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!busy && guard < 4);
        chk("busy_rise", {31'd0, busy}, 32'd1);
        len = 0;
        while (busy && len < 64) begin
            len++;
            @(negedge clk);
        end
        chk("busy_len", len, 14);
    endtask

    initial begin
        int cur;
        int v;
        int t;

        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        n_cmp = 0;
        n_bad = 0;
        num   = 13'd0;
        rst   = 1'b0;

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_anode", {28'd0, anode}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // num=0 after reset: no conversion, zeros scanned
        check_scan(0, 32);

        // Directed values
        convert(1234);
        check_scan(1234, 16);
        convert(8191);
        check_scan(8191, 16);
        convert(42);
        check_scan(42, 16);
        cur = 42;

        // Random values
        for (int k = 0; k < 8; k++) begin
            do v = int'($urandom_range(0, 8191)); while (v == cur || v == 1234);
            convert(v);
            check_scan(v, 16);
            cur = v;
        end

        // Input change mid-conversion: finish 1234, then convert 42
        @(negedge clk);
        num = 13'd1234;
        @(negedge clk);
        t = 0;
        chk("c1_busy", {31'd0, busy}, 32'd1);
        repeat (4) begin
            @(negedge clk);
            t++;
        end
        num = 13'd42;
        while (busy && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("c1_len", t, 14);
        @(negedge clk);
        t++;
        chk("c2_busy", {31'd0, busy}, 32'd1);
        while (busy && t < 80) begin
            check_digit(1234);
            @(negedge clk);
            t++;
        end
        chk("c2_within_31", {31'd0, (t <= 31)}, 32'd1);
        check_scan(42, 16);

        // Reset in the middle of a conversion
        @(negedge clk);
        num = 13'd5000;
        repeat (4) @(negedge clk);
        chk("r_busy_pre", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("r_anode", {28'd0, anode}, 32'hF);
        chk("r_seg", {25'd0, seg}, 32'h7F);
        chk("r_busy", {31'd0, busy}, 32'd0);
        num = 13'd0;
        @(negedge clk);
        rst = 1'b0;
        check_scan(0, 8);
        convert(7);
        check_scan(7, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ssd_display_driver
`default_nettype wire
